divider_8by4_seq: RTL

Sequential restoring divider: 8-bit dividend by 4-bit divisor, giving an 8-bit quotient and 4-bit remainder. It is the inverse companion of multiplier_4bit: feeding it a product and one operand recovers the other operand. It resolves one quotient bit per clock under a start/busy/done handshake, for use wherever a multiplier result must be decomposed without a large combinational array.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_step.sv | 32 +++
 rtl/divider_8by4_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants and types for the sequential restoring divider.
// Holds default widths, FSM encoding and the divide-by-zero quotient pattern.
package div_pkg;

  localparam int DFLT_DIVIDEND_W = 8;
  localparam int DFLT_DIVISOR_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [7:0] DIV0_QUOTIENT = 8'hFF;

  // Counter width needed to index one step per dividend bit (at least 1 bit)
  function automatic int iter_cnt_w(input int steps);
    return (steps > 2) ? $clog2(steps) : 1;
  endfunction

  localparam int ITER_CNT_W = iter_cnt_w(DFLT_DIVIDEND_W);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference or restore.
module div_step
  import div_pkg::*;
#(
  parameter int DIVISOR_W = DFLT_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   prem,
  input  logic                 din,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   prem_next,
  output logic                 qbit
);

  // One guard bit above the trial value so the sign of the difference is exact
  logic [DIVISOR_W+1:0] trial_s;
  logic [DIVISOR_W+1:0] diff_s;

  // Trial subtraction and restore decision
  always_comb begin
    trial_s = {prem, din};
    diff_s  = trial_s - {2'b00, divisor};
    if (diff_s[DIVISOR_W+1] == 1'b0) begin
      qbit      = 1'b1;
      prem_next = diff_s[DIVISOR_W:0];
    end else begin
      qbit      = 1'b0;
      prem_next = trial_s[DIVISOR_W:0];
    end
  end

endmodule

// File: rtl/divider_8by4_seq.sv
// Sequential restoring divider, one quotient bit per clock, with a
// start/busy/done handshake and an immediate divide-by-zero path.
module divider_8by4_seq
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DFLT_DIVIDEND_W,
  parameter int DIVISOR_W  = DFLT_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = iter_cnt_w(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

  div_state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
  // work_r shifts dividend bits out of the top while quotient bits enter at the bottom
  logic [DIVIDEND_W-1:0]  work_r, work_nxt_s;
  logic [DIVISOR_W:0]     prem_r, prem_nxt_s;
  logic [DIVISOR_W-1:0]   divisor_r, divisor_nxt_s;
  logic [DIVIDEND_W-1:0]  quotient_r, quotient_nxt_s;
  logic [DIVISOR_W-1:0]   remainder_r, remainder_nxt_s;
  logic                   dbz_r, dbz_nxt_s;
  logic                   busy_r, busy_nxt_s;
  logic                   done_r, done_nxt_s;

  logic [DIVISOR_W:0]     step_prem_s;
  logic                   step_qbit_s;

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .prem      (prem_r),
    .din       (work_r[DIVIDEND_W-1]),
    .divisor   (divisor_r),
    .prem_next (step_prem_s),
    .qbit      (step_qbit_s)
  );

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    work_nxt_s      = work_r;
    prem_nxt_s      = prem_r;
    divisor_nxt_s   = divisor_r;
    quotient_nxt_s  = quotient_r;
    remainder_nxt_s = remainder_r;
    dbz_nxt_s       = dbz_r;

    case (state_r)
      IDLE: begin
        if (start == 1'b1) begin
          if (divisor != {DIVISOR_W{1'b0}}) begin
            state_nxt_s   = RUN;
            cnt_nxt_s     = {CNT_W{1'b0}};
            work_nxt_s    = dividend;
            prem_nxt_s    = {(DIVISOR_W+1){1'b0}};
            divisor_nxt_s = divisor;
            dbz_nxt_s     = 1'b0;
          end else begin
            state_nxt_s     = DONE;
            quotient_nxt_s  = DIVIDEND_W'(DIV0_QUOTIENT);
            remainder_nxt_s = dividend[DIVISOR_W-1:0];
            dbz_nxt_s       = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        prem_nxt_s = step_prem_s;
        work_nxt_s = {work_r[DIVIDEND_W-2:0], step_qbit_s};
        cnt_nxt_s  = cnt_r + CNT_W'(1);
        if (cnt_r == LAST_CNT) begin
          state_nxt_s     = DONE;
          quotient_nxt_s  = {work_r[DIVIDEND_W-2:0], step_qbit_s};
          remainder_nxt_s = step_prem_s[DIVISOR_W-1:0];
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    busy_nxt_s = (state_nxt_s == RUN);
    done_nxt_s = (state_nxt_s == DONE);
  end

  // State, datapath and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      work_r      <= {DIVIDEND_W{1'b0}};
      prem_r      <= {(DIVISOR_W+1){1'b0}};
      divisor_r   <= {DIVISOR_W{1'b0}};
      quotient_r  <= {DIVIDEND_W{1'b0}};
      remainder_r <= {DIVISOR_W{1'b0}};
      dbz_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      work_r      <= work_nxt_s;
      prem_r      <= prem_nxt_s;
      divisor_r   <= divisor_nxt_s;
      quotient_r  <= quotient_nxt_s;
      remainder_r <= remainder_nxt_s;
      dbz_r       <= dbz_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

endmodule
